// File: rtl/sudoku_pkg.sv
// Shared sudoku definitions: board geometry, checker state encoding and the
// 3x3 box lookup used by the checker, the game FSM and the display.
package sudoku_pkg;

    localparam int N      = 9;
    localparam int CELL_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_e;

    // Row or column coordinate 0..8 to its band 0..2 without a divider.
    function automatic logic [3:0] third_of(input logic [3:0] v);
        if (v >= 4'd6)      return 4'd2;
        else if (v >= 4'd3) return 4'd1;
        else                return 4'd0;
    endfunction

    function automatic logic [3:0] box_of(input logic [3:0] x, input logic [3:0] y);
        return 4'(third_of(y) * 4'd3 + third_of(x));
    endfunction

endpackage

// File: rtl/board_check_sequencer.sv
// Scans all 81 board cells through the shared RAM read port (display has
// priority) and reports full / conflict / victory.
module board_check_sequencer
    import sudoku_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              check_start,
    input  logic              disp_req,
    input  logic [3:0]        disp_x,
    input  logic [3:0]        disp_y,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [CELL_W-1:0] disp_data,
    output logic              mem_rd_en,
    output logic [3:0]        mem_x,
    output logic [3:0]        mem_y,
    input  logic [CELL_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic              board_full,
    output logic              board_valid,
    output logic              err_valid,
    output logic [3:0]        err_x,
    output logic [3:0]        err_y
);

    localparam logic [3:0] LAST = 4'(N - 1);

    state_e       state_q, state_d;
    logic [3:0]   x_q, x_d, y_q, y_d;
    logic [3:0]   rd_x_q, rd_y_q;
    logic         scan_rd_q, disp_rd_q;
    logic [N-1:0] row_q [N];
    logic [N-1:0] row_d [N];
    logic [N-1:0] col_q [N];
    logic [N-1:0] col_d [N];
    logic [N-1:0] box_q [N];
    logic [N-1:0] box_d [N];
    logic         empty_q, empty_d;
    logic         err_valid_q, err_valid_d;
    logic [3:0]   err_x_q, err_x_d, err_y_q, err_y_d;
    logic         done_q, done_d, full_q, full_d, win_q, win_d;

    logic         scan_issue;
    logic [3:0]   box_idx, bit_idx;
    logic         dup;

    assign scan_issue  = (state_q == SCAN) && !disp_req;
    assign disp_gnt    = disp_req;
    assign mem_rd_en   = disp_req || (state_q == SCAN);
    assign mem_x       = disp_req ? disp_x : x_q;
    assign mem_y       = disp_req ? disp_y : y_q;
    assign disp_valid  = disp_rd_q;
    assign disp_data   = disp_rd_q ? mem_rd_data : '0;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign board_full  = full_q;
    assign board_valid = win_q;
    assign err_valid   = err_valid_q;
    assign err_x       = err_x_q;
    assign err_y       = err_y_q;

    // Returned datum belongs to the cell registered at issue time.
    assign box_idx = box_of(rd_x_q, rd_y_q);
    assign bit_idx = mem_rd_data - 4'd1;
    assign dup     = (mem_rd_data > 4'd9) || row_q[rd_y_q][bit_idx]
                   || col_q[rd_x_q][bit_idx] || box_q[box_idx][bit_idx];

    always_comb begin
        // NOTE: every next-state variable takes its current value first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        row_d       = row_q;
        col_d       = col_q;
        box_d       = box_q;
        empty_d     = empty_q;
        err_valid_d = err_valid_q;
        err_x_d     = err_x_q;
        err_y_d     = err_y_q;
        full_d      = full_q;
        win_d       = win_q;
        done_d      = 1'b0;

        if (scan_rd_q) begin
            if (mem_rd_data == '0) begin
                empty_d = 1'b1;
            end else if (dup) begin
                if (!err_valid_q) begin
                    err_valid_d = 1'b1;
                    err_x_d     = rd_x_q;
                    err_y_d     = rd_y_q;
                end
            end else begin
                row_d[rd_y_q][bit_idx]  = 1'b1;
                col_d[rd_x_q][bit_idx]  = 1'b1;
                box_d[box_idx][bit_idx] = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (check_start) begin
                    state_d     = SCAN;
                    x_d         = '0;
                    y_d         = '0;
                    empty_d     = 1'b0;
                    err_valid_d = 1'b0;
                    err_x_d     = '0;
                    err_y_d     = '0;
                    full_d      = 1'b0;
                    win_d       = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        row_d[i] = '0;
                        col_d[i] = '0;
                        box_d[i] = '0;
                    end
                end
            end
            SCAN: begin
                if (scan_issue) begin
                    if (x_q == LAST) begin
                        x_d = '0;
                        if (y_q == LAST) state_d = DRAIN;
                        else             y_d = y_q + 4'd1;
                    end else begin
                        x_d = x_q + 4'd1;
                    end
                end
            end
            // The final scanner read always returns during the single DRAIN cycle.
            DRAIN: state_d = REPORT;
            REPORT: begin
                full_d  = ~empty_q;
                win_d   = ~empty_q & ~err_valid_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            scan_rd_q   <= 1'b0;
            disp_rd_q   <= 1'b0;
            empty_q     <= 1'b0;
            err_valid_q <= 1'b0;
            err_x_q     <= '0;
            err_y_q     <= '0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            win_q       <= 1'b0;
            // NOTE: the masks are plain flops (27x9), so they are reset like any other state rather than treated as RAM.
            for (int i = 0; i < N; i++) begin
                row_q[i] <= '0;
                col_q[i] <= '0;
                box_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rd_x_q      <= x_q;
            rd_y_q      <= y_q;
            scan_rd_q   <= scan_issue;
            disp_rd_q   <= disp_req;
            empty_q     <= empty_d;
            err_valid_q <= err_valid_d;
            err_x_q     <= err_x_d;
            err_y_q     <= err_y_d;
            done_q      <= done_d;
            full_q      <= full_d;
            win_q       <= win_d;
            row_q       <= row_d;
            col_q       <= col_d;
            box_q       <= box_d;
        end
    end

endmodule
